platform_sprite: RTL and testbench
==================================

Name: platform_sprite

Overview:
- Parametrised successor to the single-row platform block.
- Holds the paddle's left-edge position and moves it STEP pixels per enable tick, clamped to the screen.
- On a draw request, scans a PLAT_W x PLAT_H rectangle onto the VGA write port: first erases the previously drawn position in background colour, then paints the new position.
- Sits between the game tick/keys logic and the VGA adapter; its busy/done flags let the frame sequencer arbitrate the single write port.

Parameters:
- PLAT_W, 32, paddle width in pixels (1..SCREEN_W)
- PLAT_H, 2, paddle height in rows (1..16)
- PLAT_Y, 110, top row of paddle
- SCREEN_W, 160, screen width; legal left edge is 0..SCREEN_W-PLAT_W
- INIT_X, 64, left edge after reset
- STEP, 2, pixels moved per enable tick (1..PLAT_W)
- FG_COLOUR, 3'b100, paddle colour
- BG_COLOUR, 3'b000, erase colour

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- enable  in  1  movement tick, one-cycle pulse
- left  in  1  move-left request, sampled on enable
- right  in  1  move-right request, sampled on enable
- draw  in  1  start erase+draw sequence, one-cycle pulse
- x  out  10  pixel x to VGA
- y  out  10  pixel y to VGA
- colour  out  3  pixel colour to VGA
- writeEn  out  1  pixel write strobe
- busy  out  1  high while a sequence is in progress
- done  out  1  one-cycle pulse after the last pixel write
- pos_x  out  10  current left edge, for collision logic

Behaviour:
- Reset (async, resetn=0): pos_x=INIT_X, drawn_x=INIT_X, state IDLE, counters 0, writeEn=0, busy=0, done=0. Reset mid-sequence aborts immediately; no further writes occur.
- Movement (every cycle, independent of state):
  - enable&left&!right: pos_x = (pos_x<STEP) ? 0 : pos_x-STEP.
  - enable&right&!left: pos_x = min(pos_x+STEP, SCREEN_W-PLAT_W).
  - left&right, or enable=0: hold.
- FSM states: IDLE, ERASE, PAINT, DONE.
  - IDLE: writeEn=0, busy=0. On draw, latch new_x=pos_x, clear qx and qy, go to ERASE.
  - ERASE: one pixel per cycle. x=drawn_x+qx, y=PLAT_Y+qy, colour=BG_COLOUR, writeEn=1. qx increments to PLAT_W-1, then wraps to 0 and qy increments. After pixel (PLAT_W-1, PLAT_H-1), clear counters and go to PAINT.
  - PAINT: same scan with x=new_x+qx and colour=FG_COLOUR. After the last pixel, drawn_x<=new_x and go to DONE.
  - DONE: done=1 and busy=1 for one cycle, writeEn=0, then IDLE.
- busy=1 in ERASE, PAINT and DONE.
- Latency: draw pulse to first writeEn is 1 cycle. Writes are contiguous, 2*PLAT_W*PLAT_H cycles. done follows the last write by 1 cycle.
- draw while busy is ignored, not queued.
- Movement during a sequence updates pos_x only; the in-flight new_x is unaffected and the next draw uses the updated pos_x.
- A draw with unchanged position still performs full erase+paint.
- x and y are combinational from drawn_x/new_x and counters. In IDLE and DONE: x=drawn_x, y=PLAT_Y, colour=FG_COLOUR.
- All arithmetic is 10-bit unsigned. Parameter legality guarantees no overflow.

Optional Feature:
- Macro: PLATFORM_ERASE_EN.
- Defined: full ERASE+PAINT sequence as above.
- Undefined: ERASE state is absent. draw goes IDLE->PAINT, the sequence is PLAT_W*PLAT_H writes, and drawn_x is still updated. The frame sequencer must clear the screen itself.

Test Plan (PLAT_W=4, PLAT_H=2, STEP=2, INIT_X=64, SCREEN_W=160, PLATFORM_ERASE_EN defined):
- resetn low mid-PAINT -> writeEn, busy and done 0 within the same cycle. After release, pos_x=64 and state IDLE.
- draw at reset -> 8 ERASE writes (x 64..67, y 110..111, colour 000), then 8 PAINT writes (colour 100), 16 contiguous writeEn cycles. done pulses at cycle 17 after draw.
- 33 enable+left pulses from 64 -> pos_x steps 62..0 and stays 0. 100 enable+right pulses -> pos_x saturates at 156.
- enable with left=right=1 -> pos_x unchanged. enable with left=right=0 -> unchanged.
- draw, then enable+right during ERASE -> PAINT writes x 64..67, pos_x=66. A second draw while busy is ignored. The next draw erases 64..67 and paints 66..69.
- PLATFORM_ERASE_EN undefined, draw -> exactly 8 writes, colour 100, done on cycle 9.

Source files
------------

// File: rtl/platform_sprite.sv
// rtl/platform_sprite.sv - paddle position register and rectangle erase/paint scanner; PLATFORM_ERASE_EN enables the erase pass
module platform_sprite #(
  parameter int         PLAT_W    = 32,
  parameter int         PLAT_H    = 2,
  parameter int         PLAT_Y    = 110,
  parameter int         SCREEN_W  = 160,
  parameter int         INIT_X    = 64,
  parameter int         STEP      = 2,
  parameter logic [2:0] FG_COLOUR = 3'b100,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       left,
  input  logic       right,
  input  logic       draw,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       done,
  output logic [9:0] pos_x
);

  localparam logic [9:0] MAX_X  = 10'(SCREEN_W - PLAT_W);
  localparam logic [9:0] STEP_V = 10'(STEP);
  localparam logic [9:0] INIT_V = 10'(INIT_X);
  localparam logic [9:0] Y_TOP  = 10'(PLAT_Y);
  localparam logic [9:0] LAST_X = 10'(PLAT_W - 1);
  localparam logic [9:0] LAST_Y = 10'(PLAT_H - 1);

`ifdef PLATFORM_ERASE_EN
  typedef enum logic [1:0] {IDLE, ERASE, PAINT, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;
  logic [2:0] unused_bg;
  assign unused_bg = BG_COLOUR;
`endif

  state_t     state, state_d;
  logic [9:0] new_x, new_x_d, drawn_x, drawn_x_d;
  logic [9:0] qx, qx_d, qy, qy_d;
  logic [9:0] pos_up;
  logic       last_col, last_px;

  assign pos_up   = pos_x + STEP_V;
  assign last_col = (qx == LAST_X);
  assign last_px  = last_col && (qy == LAST_Y);

  // Movement runs every cycle regardless of the scan; in-flight draws use new_x.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos_x <= INIT_V;
    end else if (enable && left && !right) begin
      pos_x <= (pos_x < STEP_V) ? 10'd0 : pos_x - STEP_V;
    end else if (enable && right && !left) begin
      pos_x <= (pos_up > MAX_X) ? MAX_X : pos_up;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      new_x   <= INIT_V;
      drawn_x <= INIT_V;
      qx      <= '0;
      qy      <= '0;
    end else begin
      state   <= state_d;
      new_x   <= new_x_d;
      drawn_x <= drawn_x_d;
      qx      <= qx_d;
      qy      <= qy_d;
    end
  end

  always_comb begin
    state_d   = state;
    new_x_d   = new_x;
    drawn_x_d = drawn_x;
    qx_d      = qx;
    qy_d      = qy;
    x         = drawn_x;
    y         = Y_TOP;
    colour    = FG_COLOUR;
    writeEn   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    // Raster advance shared by both scan passes; wraps to origin on the last pixel.
    if (state != IDLE && state != DONE) begin
      qx_d = last_col ? 10'd0 : qx + 10'd1;
      qy_d = last_px ? 10'd0 : (last_col ? qy + 10'd1 : qy);
    end
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (draw) begin
          new_x_d = pos_x;
          qx_d    = '0;
          qy_d    = '0;
`ifdef PLATFORM_ERASE_EN
          state_d = ERASE;
`else
          state_d = PAINT;
`endif
        end
      end
`ifdef PLATFORM_ERASE_EN
      ERASE: begin
        x       = drawn_x + qx;
        y       = Y_TOP + qy;
        colour  = BG_COLOUR;
        writeEn = 1'b1;
        if (last_px) state_d = PAINT;
      end
`endif
      PAINT: begin
        x       = new_x + qx;
        y       = Y_TOP + qy;
        writeEn = 1'b1;
        if (last_px) begin
          drawn_x_d = new_x;
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_platform_sprite.sv
// tb/tb_platform_sprite.sv - scoreboard bench for platform_sprite, follows PLATFORM_ERASE_EN if defined
module tb_platform_sprite;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0, left = 1'b0, right = 1'b0, draw = 1'b0;
  logic [9:0] x, y, pos_x;
  logic [2:0] colour;
  logic       writeEn, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit running = 1'b1;

`ifdef PLATFORM_ERASE_EN
  localparam int E = 8;
`else
  localparam int E = 0;
`endif
  localparam int N = E + 8;

  typedef struct {
    bit         is_done;
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] col;
  } ev_t;

  ev_t sb[$];

  platform_sprite #(
    .PLAT_W(4), .PLAT_H(2), .PLAT_Y(110), .SCREEN_W(160), .INIT_X(64), .STEP(2),
    .FG_COLOUR(3'b100), .BG_COLOUR(3'b000)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .left(left), .right(right), .draw(draw),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy), .done(done), .pos_x(pos_x)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input bit d, input int t, input logic [9:0] ex, input logic [9:0] ey, input logic [2:0] ec);
    ev_t e;
    e.is_done = d; e.cyc = t; e.x = ex; e.y = ey; e.col = ec;
    sb.push_back(e);
  endtask

  // First write lands one cycle after the draw-sampling edge.
  task automatic push_draw(input logic [9:0] ex, input logic [9:0] px);
    int t;
    t = cyc + 1;
    if (E > 0) begin
      for (int qy = 0; qy < 2; qy++)
        for (int qx = 0; qx < 4; qx++) begin
          push_ev(1'b0, t, ex + 10'(qx), 10'(110 + qy), 3'b000);
          t++;
        end
    end
    for (int qy = 0; qy < 2; qy++)
      for (int qx = 0; qx < 4; qx++) begin
        push_ev(1'b0, t, px + 10'(qx), 10'(110 + qy), 3'b100);
        t++;
      end
    push_ev(1'b1, t, 10'd0, 10'd0, 3'b000);
  endtask

  task automatic issue_draw(input logic [9:0] ex, input logic [9:0] px);
    push_draw(ex, px);
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
  endtask

  task automatic monitor();
    ev_t e;
    while (running) begin
      @(negedge clk);
      if (writeEn || done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL scan_unexpected: got we=%0b done=%0b x=%0d y=%0d at cyc %0d, required no output",
                   writeEn, done, x, y, cyc);
        end else begin
          e = sb.pop_front();
          if (done !== e.is_done || writeEn !== !e.is_done || busy !== 1'b1 || cyc != e.cyc ||
              (!e.is_done && (x !== e.x || y !== e.y || colour !== e.col))) begin
            errors++;
            $display("FAIL scan: got done=%0b we=%0b busy=%0b x=%0d y=%0d col=%b cyc=%0d, required done=%0b x=%0d y=%0d col=%b cyc=%0d",
                     done, writeEn, busy, x, y, colour, cyc, e.is_done, e.x, e.y, e.col, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    int exp;
    repeat (2) @(negedge clk);
    chk("reset_pos_x", pos_x, 64);
    chk("reset_we", writeEn, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_x", x, 64);
    chk("reset_y", y, 110);
    chk("reset_colour", colour, 3'b100);
    resetn = 1'b1;
    @(negedge clk);

    issue_draw(10'd64, 10'd64);
    chk("busy_in_seq", busy, 1);
    repeat (N + 2) @(negedge clk);
    chk("idle_after_seq", busy, 0);
    chk("idle_x", x, 64);

    // Move right during the scan, plus a draw while busy that must be dropped.
    push_draw(10'd64, 10'd64);
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0; enable = 1'b1; right = 1'b1;
    @(negedge clk);
    enable = 1'b0; right = 1'b0;
    repeat (2) @(negedge clk);
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    repeat (N) @(negedge clk);
    chk("pos_after_move", pos_x, 66);
    chk("sb_after_move", sb.size(), 0);
    issue_draw(10'd64, 10'd66);
    repeat (N + 2) @(negedge clk);
    chk("drawn_x_updated", x, 66);

    // Reset in the middle of the paint pass.
    push_draw(10'd66, 10'd66);
    draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    repeat (E + 2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_we", writeEn, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("abort_pos_x", pos_x, 64);
    chk("abort_drawn_x", x, 64);
    repeat (5) @(negedge clk);
    chk("abort_idle", busy, 0);
    issue_draw(10'd64, 10'd64);
    repeat (N + 2) @(negedge clk);

    enable = 1'b1; left = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      exp = 64 - 2 * i;
      if (exp < 0) exp = 0;
      chk("left_step", pos_x, exp);
    end
    left = 1'b0; right = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      exp = 2 * i;
      if (exp > 156) exp = 156;
      chk("right_step", pos_x, exp);
    end
    right = 1'b0; left = 1'b1;
    @(negedge clk);
    chk("left_from_max", pos_x, 154);
    right = 1'b1;
    @(negedge clk);
    chk("both_hold", pos_x, 154);
    enable = 1'b0; right = 1'b0;
    @(negedge clk);
    chk("no_enable_hold", pos_x, 154);
    left = 1'b0;

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    running = 1'b0;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
